// File: rtl/imu_sample_reader.sv
// Periodic 6-byte IMU burst reader: requests a burst each sample period, collects the
// big-endian words, scales/saturates them to 10 bits. Define IMU_TIMEOUT_EN for a byte-gap abort.
module imu_sample_reader #(
    parameter int unsigned SamplePeriod  = 50000,
    parameter logic [7:0]  BurstAddr     = 8'h3B,
    parameter int unsigned ScaleShift    = 5,
    parameter int unsigned TimeoutCycles = 1000
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic              ReqValid,
    output logic [7:0]        ReqAddr,
    output logic [2:0]        ReqLen,
    input  logic              ReqReady,
    input  logic              ByteValid,
    input  logic [7:0]        ByteData,
    input  logic              BusError,
    output logic signed [9:0] Accel1,
    output logic signed [9:0] Accel2,
    output logic signed [9:0] Gyro,
    output logic              DataReady,
    output logic              SampleMissed,
    output logic [7:0]        ErrorCount
);

    localparam int CntW = (SamplePeriod > 1) ? $clog2(SamplePeriod) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_COLLECT,
        ST_CONVERT,
        ST_PUBLISH
    } state_t;

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [5:0][7:0]   buf_q, buf_d;
    logic [7:0]        err_q, err_d;
    logic signed [9:0] accel1_q, accel1_d;
    logic signed [9:0] accel2_q, accel2_d;
    logic signed [9:0] gyro_q, gyro_d;
    logic              tick;
    logic              timeout;

    function automatic logic signed [9:0] scale_sat(input logic [15:0] raw);
        logic signed [15:0] sh;
        sh = $signed(raw) >>> ScaleShift;
        if (sh > 16'sd511) begin
            return 10'sh1FF;
        end else if (sh < -16'sd512) begin
            return 10'sh200;
        end
        return sh[9:0];
    endfunction

    assign tick = (cnt_q == CntW'(SamplePeriod - 1));

`ifdef IMU_TIMEOUT_EN
    localparam int GapW = $clog2(TimeoutCycles + 1);
    logic [GapW-1:0] gap_q, gap_d;

    // Counts consecutive byte-less COLLECT cycles; the TimeoutCycles-th one aborts.
    always_comb begin
        gap_d   = '0;
        timeout = 1'b0;
        if (state_q == ST_COLLECT && !ByteValid) begin
            gap_d   = gap_q + 1'b1;
            timeout = (gap_q == GapW'(TimeoutCycles - 1));
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        buf_d    = buf_q;
        err_d    = err_q;
        accel1_d = accel1_q;
        accel2_d = accel2_q;
        gyro_d   = gyro_q;
        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (BusError) begin
                    state_d = ST_IDLE;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end else if (ReqReady) begin
                    state_d = ST_COLLECT;
                    idx_d   = '0;
                end
            end
            ST_COLLECT: begin
                // An error on the sixth byte still wins over completion.
                if (BusError || timeout) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end else if (ByteValid) begin
                    buf_d[idx_q] = ByteData;
                    idx_d        = idx_q + 3'd1;
                    if (idx_q == 3'd5) begin
                        state_d = ST_CONVERT;
                    end
                end
            end
            ST_CONVERT: begin
                accel1_d = scale_sat({buf_q[0], buf_q[1]});
                accel2_d = scale_sat({buf_q[2], buf_q[3]});
                gyro_d   = scale_sat({buf_q[4], buf_q[5]});
                state_d  = ST_PUBLISH;
            end
            ST_PUBLISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            buf_q    <= '0;
            err_q    <= '0;
            accel1_q <= '0;
            accel2_q <= '0;
            gyro_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            buf_q    <= buf_d;
            err_q    <= err_d;
            accel1_q <= accel1_d;
            accel2_q <= accel2_d;
            gyro_q   <= gyro_d;
        end
    end

    assign ReqValid     = (state_q == ST_REQ);
    assign ReqAddr      = BurstAddr;
    assign ReqLen       = 3'd6;
    assign DataReady    = (state_q == ST_PUBLISH);
    assign SampleMissed = tick && (state_q != ST_IDLE);
    assign ErrorCount   = err_q;
    assign Accel1       = accel1_q;
    assign Accel2       = accel2_q;
    assign Gyro         = gyro_q;

endmodule

// File: tb/tb_imu_sample_reader.sv
// Randomized scoreboard bench for imu_sample_reader: driver pushes expected samples,
// a negedge monitor pops them on DataReady and checks outputs hold between strobes.
module tb_imu_sample_reader;

    localparam int P  = 40;
    localparam int TO = 30;

    logic              clk = 1'b0;
    logic              Reset;
    logic              ReqValid;
    logic [7:0]        ReqAddr;
    logic [2:0]        ReqLen;
    logic              ReqReady;
    logic              ByteValid;
    logic [7:0]        ByteData;
    logic              BusError;
    logic signed [9:0] Accel1;
    logic signed [9:0] Accel2;
    logic signed [9:0] Gyro;
    logic              DataReady;
    logic              SampleMissed;
    logic [7:0]        ErrorCount;

    imu_sample_reader #(
        .SamplePeriod (P),
        .BurstAddr    (8'h3B),
        .ScaleShift   (5),
        .TimeoutCycles(TO)
    ) dut (
        .Clock       (clk),
        .Reset       (Reset),
        .ReqValid    (ReqValid),
        .ReqAddr     (ReqAddr),
        .ReqLen      (ReqLen),
        .ReqReady    (ReqReady),
        .ByteValid   (ByteValid),
        .ByteData    (ByteData),
        .BusError    (BusError),
        .Accel1      (Accel1),
        .Accel2      (Accel2),
        .Gyro        (Gyro),
        .DataReady   (DataReady),
        .SampleMissed(SampleMissed),
        .ErrorCount  (ErrorCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a1;
        int a2;
        int g;
        int cyc;
    } samp_t;

    samp_t q[$];
    samp_t cur = '{0, 0, 0, 0};
    int    checks   = 0;
    int    errors   = 0;
    int    cyc      = 0;
    int    miss_cnt = 0;
    int    err_exp  = 0;
    bit    mon_en   = 1'b0;
    bit    rst_d    = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: signed 16-bit word, divide by 32 rounding toward -inf, clamp to 10 bits.
    function automatic int conv(input logic [7:0] hi, input logic [7:0] lo);
        int w, s;
        w = int'(hi) * 256 + int'(lo);
        if (w >= 32768) w -= 65536;
        if (w >= 0) s = w / 32;
        else s = -((-w + 31) / 32);
        if (s > 511) s = 511;
        if (s < -512) s = -512;
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: an edge with Reset high clears the model; DataReady pops the scoreboard.
    initial begin
        samp_t e;
        forever begin
            @(negedge clk);
            if (rst_d) begin
                cur = '{0, 0, 0, 0};
                q.delete();
            end
            rst_d = Reset;
            if (mon_en) begin
                if (SampleMissed) miss_cnt++;
                if (DataReady) begin
                    if (q.size() == 0) begin
                        chk("spurious_ready", int'(DataReady), 0);
                    end else begin
                        e = q.pop_front();
                        chk("ready_cycle", cyc, e.cyc);
                        cur = e;
                    end
                end
                chk("accel1", int'(Accel1), cur.a1);
                chk("accel2", int'(Accel2), cur.a2);
                chk("gyro", int'(Gyro), cur.g);
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (!ReqValid && n < 3 * P) begin
            step();
            n++;
        end
        chk("req_seen", int'(ReqValid), 1);
        chk("req_addr", int'(ReqAddr), 8'h3B);
        chk("req_len", int'(ReqLen), 6);
    endtask

    // err_pos: -1 none, 0..5 error at that byte slot, 6 error while requesting.
    task automatic run_burst(input logic [7:0] b[6], input int err_pos,
                             input bit err_with_byte, input bit do_wait);
        samp_t s;
        if (do_wait) wait_req();
        if (!ReqValid) return;
        repeat ($urandom_range(0, 3)) step();
        if (err_pos == 6) begin
            BusError = 1'b1;
            step();
            BusError = 1'b0;
            err_exp++;
            chk("err_count_req", int'(ErrorCount), err_exp);
            return;
        end
        ReqReady = 1'b1;
        step();
        ReqReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 2)) step();
            if (i == err_pos && !err_with_byte) begin
                BusError = 1'b1;
                step();
                BusError = 1'b0;
                err_exp++;
                chk("err_count_gap", int'(ErrorCount), err_exp);
                return;
            end
            ByteValid = 1'b1;
            ByteData  = b[i];
            BusError  = (i == err_pos);
            step();
            ByteValid = 1'b0;
            BusError  = 1'b0;
            if (i == err_pos) begin
                err_exp++;
                chk("err_count_byte", int'(ErrorCount), err_exp);
                return;
            end
        end
        s.a1  = conv(b[0], b[1]);
        s.a2  = conv(b[2], b[3]);
        s.g   = conv(b[4], b[5]);
        s.cyc = cyc + 1;
        q.push_back(s);
        // A stray byte during CONVERT must be ignored.
        ByteValid = 1'b1;
        ByteData  = 8'($urandom);
        step();
        ByteValid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b[6];
        int m0, bad, ep;
        bit wb;
        Reset = 1'b1; ReqReady = 1'b0; ByteValid = 1'b0; ByteData = '0; BusError = 1'b0;
        repeat (3) step();
        Reset  = 1'b0;
        mon_en = 1'b1;
        chk("rst_accel1", int'(Accel1), 0);
        chk("rst_gyro", int'(Gyro), 0);
        chk("rst_err", int'(ErrorCount), 0);
        chk("rst_reqvalid", int'(ReqValid), 0);
        chk("rst_ready", int'(DataReady), 0);

        run_burst('{8'h12, 8'h40, 8'hFF, 8'hC0, 8'h7F, 8'hFF}, -1, 1'b0, 1'b1);
        run_burst('{8'h80, 8'h00, 8'h00, 8'h1F, 8'hFF, 8'hE0}, -1, 1'b0, 1'b1);
        run_burst('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 3, 1'b0, 1'b1);
        chk("err_after_3rd", int'(ErrorCount), 1);
        run_burst('{8'h20, 8'h00, 8'hE0, 8'h00, 8'h00, 8'h40}, -1, 1'b0, 1'b1);
        run_burst('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 5, 1'b1, 1'b1);

        m0 = miss_cnt;
        for (int k = 0; k < 20; k++) begin
            foreach (b[j]) b[j] = 8'($urandom);
            ep = -1;
            wb = 1'b0;
            if ($urandom_range(0, 7) >= 5) begin
                ep = $urandom_range(0, 6);
                wb = 1'($urandom_range(0, 1));
            end
            run_burst(b, ep, wb, 1'b1);
        end
        chk("no_miss_random", miss_cnt - m0, 0);
        chk("err_total", int'(ErrorCount), err_exp);

        // Bus master stalls for three whole periods.
        wait_req();
        m0  = miss_cnt;
        bad = 0;
        for (int k = 0; k < 3 * P; k++) begin
            if (!ReqValid) bad++;
            step();
        end
        chk("req_held", bad, 0);
        chk("missed_3", miss_cnt - m0, 3);
        run_burst('{8'h00, 8'h40, 8'hFF, 8'hFF, 8'h12, 8'h34}, -1, 1'b0, 1'b0);

        // Reset after the fourth byte.
        wait_req();
        ReqReady = 1'b1;
        step();
        ReqReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ByteValid = 1'b1;
            ByteData  = 8'h7F;
            step();
        end
        ByteValid = 1'b0;
        Reset = 1'b1;
        step();
        Reset   = 1'b0;
        err_exp = 0;
        chk("rst_mid_err", int'(ErrorCount), 0);
        chk("rst_mid_accel1", int'(Accel1), 0);
        run_burst('{8'hF0, 8'h00, 8'h05, 8'h00, 8'h80, 8'h01}, -1, 1'b0, 1'b1);

        // Source stops after two bytes.
        wait_req();
        ReqReady = 1'b1;
        step();
        ReqReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ByteValid = 1'b1;
            ByteData  = 8'h55;
            step();
        end
        ByteValid = 1'b0;
        m0  = miss_cnt;
        bad = 0;
        for (int k = 0; k < 3 * P; k++) begin
            if (ReqValid) bad++;
            step();
        end
`ifdef IMU_TIMEOUT_EN
        err_exp++;
        chk("timeout_err", int'(ErrorCount), err_exp);
`else
        chk("stuck_no_req", bad, 0);
        chk("stuck_missed", miss_cnt - m0, 3);
        chk("stuck_err", int'(ErrorCount), err_exp);
`endif
        Reset = 1'b1;
        step();
        Reset   = 1'b0;
        err_exp = 0;
        run_burst('{8'h12, 8'h40, 8'hFF, 8'hC0, 8'h7F, 8'hFF}, -1, 1'b0, 1'b1);

        bad = 0;
        while (q.size() != 0 && bad < 10) begin
            step();
            bad++;
        end
        step();
        chk("queue_drained", q.size(), 0);
        chk("final_err", int'(ErrorCount), err_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
